// File: rtl/register_file_pkg.sv
// Shared processor package: datapath widths, the hard-wired zero register
// index and the ALU operation encoding used by both the register file and
// the ALU.
package register_file_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;

  // Architectural x0: reads as zero, writes are discarded.
  localparam int ZERO_REG = 0;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5
  } aluOp_t;

endpackage

// File: rtl/register_file_write_stats.sv
// Per-register saturating write counters plus a running-maximum tracker that
// reports the most-written register index. A tie with the current maximum
// keeps the earlier index; a saturated counter never moves the maximum.
module regfile_write_stats
  import register_file_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  writeValid,
  input  logic [ADDR_WIDTH-1:0] writeAddr,
  output logic [ADDR_WIDTH-1:0] regMostWritten
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic [CNT_WIDTH-1:0] counts [NUM_REGS];
  logic [CNT_WIDTH-1:0] maxCount;
  logic [CNT_WIDTH-1:0] curCount;
  logic [CNT_WIDTH-1:0] nextCount;
  logic                 saturated;

  // Look up the addressed counter and form its incremented value.
  always_comb begin
    curCount  = counts[writeAddr];
    saturated = &curCount;
    nextCount = curCount + CNT_WIDTH'(1);
  end

  // Bump the counter on an effective write and update the running maximum.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) counts[i] <= '0;
      maxCount       <= '0;
      regMostWritten <= '0;
    end else if (writeValid && !saturated) begin
      counts[writeAddr] <= nextCount;
      if (nextCount > maxCount) begin
        maxCount       <= nextCount;
        regMostWritten <= writeAddr;
      end
    end
  end

endmodule

// File: rtl/register_file.sv
// Two-read / one-write register file with x0 hard-wired to zero, access
// counters and write statistics. Reads are combinational. Define
// REGFILE_BYPASS_EN to forward a same-cycle write to the read ports
// (write-first); without it a colliding read returns the old value.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] readAddrA,
  input  logic [ADDR_WIDTH-1:0] readAddrB,
  input  logic                  readEn,
  output logic [DATA_WIDTH-1:0] readDataA,
  output logic [DATA_WIDTH-1:0] readDataB,
  input  logic                  writeEn,
  input  logic [ADDR_WIDTH-1:0] writeAddr,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic [31:0]           readTotal,
  output logic [31:0]           writeTotal,
  output logic [ADDR_WIDTH-1:0] regMostWritten,
  output logic                  writeActive
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  writeValid;

  // A write counts only when enabled and not aimed at x0.
  assign writeValid = writeEn && (writeAddr != ZERO_IDX);

  // Storage update; x0 is never written so it stays at its reset value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (writeValid) begin
      regs[writeAddr] <= writeData;
    end
  end

  // Read port A: x0 forced to zero, optional same-cycle write forwarding.
  always_comb begin
    readDataA = regs[readAddrA];
`ifdef REGFILE_BYPASS_EN
    if (writeValid && (readAddrA == writeAddr)) readDataA = writeData;
`endif
    if (readAddrA == ZERO_IDX) readDataA = '0;
  end

  // Read port B: identical selection logic to port A.
  always_comb begin
    readDataB = regs[readAddrB];
`ifdef REGFILE_BYPASS_EN
    if (writeValid && (readAddrB == writeAddr)) readDataB = writeData;
`endif
    if (readAddrB == ZERO_IDX) readDataB = '0;
  end

  // Wrapping access counters and the one-cycle-delayed write indicator.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readTotal   <= '0;
      writeTotal  <= '0;
      writeActive <= 1'b0;
    end else begin
      if (readEn) readTotal <= readTotal + 32'd1;
      if (writeValid) writeTotal <= writeTotal + 32'd1;
      writeActive <= writeValid;
    end
  end

  regfile_write_stats #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_stats (
    .clk           (clk),
    .reset         (reset),
    .writeValid    (writeValid),
    .writeAddr     (writeAddr),
    .regMostWritten(regMostWritten)
  );

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed scenarios followed by random traffic,
// all checked against a behavioural model of the register file.
module tb_register_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam int NR = 32;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic [AW-1:0] readAddrA;
  logic [AW-1:0] readAddrB;
  logic          readEn;
  logic [DW-1:0] readDataA;
  logic [DW-1:0] readDataB;
  logic          writeEn;
  logic [AW-1:0] writeAddr;
  logic [DW-1:0] writeData;
  logic [31:0]   readTotal;
  logic [31:0]   writeTotal;
  logic [AW-1:0] regMostWritten;
  logic          writeActive;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state.
  logic [DW-1:0] mRegs [NR];
  int            mCnt [NR];
  int            mReach [NR];
  int            seqNo;
  logic [31:0]   mRead;
  logic [31:0]   mWrite;
  logic          mActive;

  register_file #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .readAddrA     (readAddrA),
    .readAddrB     (readAddrB),
    .readEn        (readEn),
    .readDataA     (readDataA),
    .readDataB     (readDataB),
    .writeEn       (writeEn),
    .writeAddr     (writeAddr),
    .writeData     (writeData),
    .readTotal     (readTotal),
    .writeTotal    (writeTotal),
    .regMostWritten(regMostWritten),
    .writeActive   (writeActive)
  );

  // Clock: posedges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NR; i++) begin
      mRegs[i]  = '0;
      mCnt[i]   = 0;
      mReach[i] = 0;
    end
    seqNo   = 0;
    mRead   = '0;
    mWrite  = '0;
    mActive = 1'b0;
  endtask

  // Most-written register: highest count; among equal counts the register
  // that reached that count first; 0 when nothing has been written.
  function automatic logic [AW-1:0] expMost();
    int best = 0;
    for (int r = 1; r < NR; r++) begin
      if (mCnt[r] > mCnt[best] ||
          (mCnt[r] == mCnt[best] && mCnt[r] > 0 && mReach[r] < mReach[best]))
        best = r;
    end
    return AW'(best);
  endfunction

  function automatic logic [DW-1:0] expRead(input logic [AW-1:0] ra, input logic we,
                                            input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    if (ra == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we && wa != 0 && wa == ra) return wd;
`endif
    return mRegs[ra];
  endfunction

  // One bus cycle, entered shortly after a rising edge: drive, check the
  // combinational reads, let the edge happen, check the registered outputs.
  task automatic cyc(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                     input logic re, input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    logic eff;
    writeEn = we; writeAddr = wa; writeData = wd;
    readEn = re; readAddrA = ra; readAddrB = rb;
    #1;
    chk("readDataA", readDataA, expRead(ra, we, wa, wd));
    chk("readDataB", readDataB, expRead(rb, we, wa, wd));
    eff = we && (wa != 0);
    if (re) mRead = mRead + 32'd1;
    if (eff) begin
      mRegs[wa] = wd;
      mWrite = mWrite + 32'd1;
      if (mCnt[wa] < CNT_MAX) begin
        mCnt[wa]++;
        seqNo++;
        mReach[wa] = seqNo;
      end
    end
    mActive = eff;
    @(posedge clk);
    #1;
    chk("readTotal", readTotal, mRead);
    chk("writeTotal", writeTotal, mWrite);
    chk("regMostWritten", 32'(regMostWritten), 32'(expMost()));
    chk("writeActive", 32'(writeActive), 32'(mActive));
  endtask

  initial begin
    logic [AW-1:0] wa, ra, rb;
    logic we, re;
    logic [DW-1:0] wd;
    logic [DW-1:0] sum;

    reset = 1'b0;
    writeEn = 1'b0; writeAddr = '0; writeData = '0;
    readEn = 1'b0; readAddrA = 5'd5; readAddrB = 5'd31;
    modelReset();

    // Reset state, before any clock edge.
    #3;
    chk("rst_readDataA", readDataA, 32'h0);
    chk("rst_readDataB", readDataB, 32'h0);
    chk("rst_readTotal", readTotal, 32'h0);
    chk("rst_writeTotal", writeTotal, 32'h0);
    chk("rst_regMostWritten", 32'(regMostWritten), 32'h0);
    chk("rst_writeActive", 32'(writeActive), 32'h0);

    #9 reset = 1'b1;
    @(posedge clk);
    #1;

    // x5 write then dual read.
    cyc(1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 5'd0);
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5);
    chk("x5_writeTotal", writeTotal, 32'd1);

    // Write to x0 is ignored.
    cyc(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd5);
    chk("x0_writeActive", 32'(writeActive), 32'h0);
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);

    // Same-cycle write/read collision on x7, then the stored value.
    cyc(1'b1, 5'd7, 32'hCAFEF00D, 1'b1, 5'd7, 5'd5);
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7);

    // Most-written tracking with a tie: x3 x3, x9 x3, x9 once more.
    for (int i = 0; i < 3; i++) cyc(1'b1, 5'd3, 32'(i), 1'b0, 5'd3, 5'd9);
    for (int i = 0; i < 3; i++) cyc(1'b1, 5'd9, 32'(i), 1'b0, 5'd3, 5'd9);
    chk("tie_keeps_x3", 32'(regMostWritten), 32'd3);
    cyc(1'b1, 5'd9, 32'h99, 1'b0, 5'd3, 5'd9);
    chk("x9_overtakes", 32'(regMostWritten), 32'd9);

    // x4 then ten reads, then an asynchronous reset between edges.
    cyc(1'b1, 5'd4, 32'h55, 1'b1, 5'd4, 5'd4);
    for (int i = 0; i < 10; i++) cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'(i));
    #2;
    writeEn = 1'b0; readAddrA = 5'd4; readAddrB = 5'd9;
    reset = 1'b0;
    modelReset();
    #1;
    chk("async_x4", readDataA, 32'h0);
    chk("async_x9", readDataB, 32'h0);
    chk("async_readTotal", readTotal, 32'h0);
    chk("async_writeTotal", writeTotal, 32'h0);
    chk("async_regMostWritten", 32'(regMostWritten), 32'h0);

    // A write held across an edge while reset is low is dropped.
    writeEn = 1'b1; writeAddr = 5'd4; writeData = 32'hAA;
    @(posedge clk);
    #1;
    chk("rstwr_x4", readDataA, 32'h0);
    chk("rstwr_writeTotal", writeTotal, 32'h0);
    chk("rstwr_writeActive", 32'(writeActive), 32'h0);
    reset = 1'b1;
    cyc(1'b1, 5'd4, 32'hAA, 1'b0, 5'd4, 5'd4);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd4, 5'd0);

    // ALU chain: x1=15, x2=25, ADD -> x3, read back.
    cyc(1'b1, 5'd1, 32'd15, 1'b0, 5'd0, 5'd0);
    cyc(1'b1, 5'd2, 32'd25, 1'b0, 5'd0, 5'd0);
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 5'd2);
    sum = readDataA + readDataB;
    chk("alu_sum", sum, 32'd40);
    cyc(1'b1, 5'd3, sum, 1'b0, 5'd0, 5'd0);
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3);
    chk("alu_x3", readDataA, 32'd40);

    // Saturation: x6 runs past the counter limit, then x8 only ties it.
    for (int i = 0; i < 20; i++) cyc(1'b1, 5'd6, $urandom, 1'b0, 5'd6, 5'd8);
    chk("sat_x6", 32'(regMostWritten), 32'd6);
    for (int i = 0; i < 20; i++) cyc(1'b1, 5'd8, $urandom, 1'b1, 5'd6, 5'd8);
    chk("sat_tie_x6", 32'(regMostWritten), 32'd6);

    // Random traffic, addresses mostly clustered to force collisions.
    for (int i = 0; i < 300; i++) begin
      we = ($urandom_range(0, 3) != 0);
      wa = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
      wd = $urandom;
      re = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 7));
      rb = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 31));
      cyc(we, wa, wd, re, ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register index width (32 registers).
REQ-003 SHALL have parameter CNT_WIDTH, default 16, per-register write-counter width.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports readAddrA, readAddrB  input  ADDR_WIDTH  source register indices.
REQ-007 SHALL have port readEn  input  1  read-valid qualifier, used for statistics only.
REQ-008 SHALL have ports readDataA, readDataB  output  DATA_WIDTH  operands to the ALU operandA/operandB.
REQ-009 SHALL have ports writeEn  input  1, writeAddr  input  ADDR_WIDTH, writeData  input  DATA_WIDTH  writeback port from ALU result.
REQ-010 SHALL have ports readTotal, writeTotal  output  32  access counters.
REQ-011 SHALL have port regMostWritten  output  ADDR_WIDTH  most-written register index.
REQ-012 SHALL have port writeActive  output  1  registered copy of the previous cycle's effective write.

Function
REQ-013 SHALL read combinationally: readDataX = reg[readAddrX], zero latency.
REQ-014 SHALL return 0 for index 0 on either read port, always.
REQ-015 SHALL write writeData into reg[writeAddr] on a rising edge with writeEn=1 and writeAddr!=0; the new value is visible one cycle later.
REQ-016 SHALL ignore writes to index 0: no storage change, no counter change, writeActive=0.
REQ-017 SHALL increment readTotal by 1 per cycle with readEn=1, wrapping modulo 2^32.
REQ-018 SHALL increment writeTotal by 1 per effective write (REQ-015), wrapping modulo 2^32.
REQ-019 SHALL keep a CNT_WIDTH write counter per register, saturating at all-ones.
REQ-020 SHALL hold a running maximum; on an effective write to r, if the incremented count[r] > maxCount, then regMostWritten<=r and maxCount<=the incremented count; ties keep the previous index.
REQ-021 SHALL, once count[r] saturates, make no further maxCount/regMostWritten change from writes to r.
REQ-022 SHALL, when both read ports address the same register, return identical data on both.

Reset
REQ-023 SHALL, while reset=0, asynchronously clear all registers, per-register counters, maxCount, readTotal, writeTotal, regMostWritten and writeActive to 0.
REQ-024 SHALL drop any write coinciding with reset assertion; the first write takes effect on the first rising edge with reset=1.

Configuration
REQ-025 SHALL, with macro REGFILE_BYPASS_EN defined, forward writeData to readDataX in the same cycle when writeEn=1, writeAddr!=0 and readAddrX==writeAddr (write-first).
REQ-026 SHALL, without REGFILE_BYPASS_EN, return the old stored value in that case (read-first); all other behaviour is identical.

Structure
REQ-027 SHALL take DATA_WIDTH/ADDR_WIDTH defaults and the zero-register index constant from the shared processor package, which the ALU uses as well.
REQ-028 SHALL place the per-register saturating counters and the running-max tracker in one sub-module, regfile_write_stats; storage and read muxing stay in register_file.

Verification
REQ-029 SHALL cover: write x5=0x12345678, then read A=5, B=5 next cycle -> both 0x12345678; writeTotal=1.
REQ-030 SHALL cover: writeEn=1, writeAddr=0, writeData=0xFFFFFFFF, then read A=0 -> 0x00000000; writeTotal unchanged; writeActive=0.
REQ-031 SHALL cover: same-cycle write x7=0xCAFEF00D with readAddrA=7 (x7 previously 0) -> 0xCAFEF00D with REGFILE_BYPASS_EN, 0x00000000 without; next cycle 0xCAFEF00D in both builds.
REQ-032 SHALL cover: write x3 three times, then x9 three times, then x9 once more -> regMostWritten=3 after the x9 tie, and 9 after the fourth x9 write.
REQ-033 SHALL cover: reset pulled low mid-sequence after x4=0x55 and 10 reads -> x4 reads 0, readTotal=0, writeTotal=0 and regMostWritten=0, all immediately and without a clock edge.
REQ-034 SHALL cover: ALU-chain smoke test: x1=15, x2=25, read A=1, B=2 into the ALU with ADD -> ALU result 40 written to x3; reading x3 then returns 40.
